// File: rtl/waveform_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// waveform_sequencer_pkg
// Shared definitions for the waveform sequencer:
//   seq_state_t : playback FSM states (IDLE, RUN, FINISH)
//   func_sel_t  : waveform-generator select codes, including FUNC_ZERO which
//                 parks the generator at a zero output
//   FUNC_W      : width of a waveform select
// -----------------------------------------------------------------------------
package waveform_sequencer_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_t;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_RHOMBOID   = 3'b000,
    FUNC_SQUARE     = 3'b001,
    FUNC_RECIPROCAL = 3'b010,
    FUNC_TRIANGLE   = 3'b011,
    FUNC_FULL_WAVE  = 3'b100,
    FUNC_HALF_WAVE  = 3'b101,
    FUNC_SINUSOIDAL = 3'b110,
    FUNC_ZERO       = 3'b111
  } func_sel_t;

endpackage

// File: rtl/waveform_sequencer_if.sv
// -----------------------------------------------------------------------------
// waveform_sequencer_if
// Bundles the playlist configuration port, playback control and playback
// status of the waveform sequencer.
//   cfg_we/cfg_addr/cfg_func/cfg_dwell : playlist entry write
//   cfg_last                           : index of final entry (sampled on start)
//   loop, start, stop                  : playback control
//   func, entry_idx, busy, done        : playback status / generator select
// Modports:
//   master : the controller driving configuration and control
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface waveform_sequencer_if #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [2:0]         cfg_func;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [ADDR_W-1:0]  cfg_last;
  logic               loop;
  logic               start;
  logic               stop;
  logic [2:0]         func;
  logic [ADDR_W-1:0]  entry_idx;
  logic               busy;
  logic               done;

  modport master (
    output cfg_we, cfg_addr, cfg_func, cfg_dwell, cfg_last, loop, start, stop,
    input  func, entry_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_func, cfg_dwell, cfg_last, loop, start, stop,
    output func, entry_idx, busy, done
  );

endinterface

// File: rtl/waveform_sequencer_dwell_timer.sv
// -----------------------------------------------------------------------------
// waveform_sequencer_dwell_timer
// Prescale-plus-dwell counter that times how long one playlist entry is held.
// An entry lasts max(dwell,1)*PRESCALE ticks; expire is high during the final
// tick so the next entry can be loaded on that same edge without a gap.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   load     : reload both counters from dwell (wins over tick)
//   dwell    : dwell units of the entry being loaded
//   tick     : count enable (high while playing)
//   expire   : last tick of the current entry
// -----------------------------------------------------------------------------
module waveform_sequencer_dwell_timer #(
  parameter int DWELL_W  = 8,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               tick,
  output logic               expire
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]   pre_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  assign expire = tick && (pre_cnt == '0) && (dwell_cnt == '0);

  // Both counters count down to zero; a dwell of 0 is loaded as if it were 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt   <= '0;
      dwell_cnt <= '0;
    end else if (load) begin
      pre_cnt   <= PRE_MAX;
      dwell_cnt <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end else if (tick && !expire) begin
      if (pre_cnt == '0) begin
        pre_cnt   <= PRE_MAX;
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end else begin
        pre_cnt <= pre_cnt - PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/waveform_sequencer.sv
// -----------------------------------------------------------------------------
// waveform_sequencer
// Plays a programmable playlist of waveform selects. Each entry holds a
// waveform code and a dwell count; during playback the entry's code is driven
// on func for max(dwell,1)*PRESCALE cycles, then the next entry follows with
// no gap. After the final entry playback either wraps to entry 0 (loop=1) or
// finishes with a one-cycle done pulse.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   sif      : waveform_sequencer_if slave modport (config, control, status)
// -----------------------------------------------------------------------------
module waveform_sequencer #(
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 8,
  parameter int PRESCALE = 4
) (
  input logic                  clk,
  input logic                  rst,
  waveform_sequencer_if.slave  sif
);

  import waveform_sequencer_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic [FUNC_W-1:0]  func_mem  [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];

  seq_state_t         state;
  seq_state_t         next_state;
  logic [FUNC_W-1:0]  func_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W-1:0]  last_q;
  logic [ADDR_W-1:0]  load_idx;
  logic               load_en;
  logic               latch_last;
  logic               running;
  logic               expire;

  assign running = (state == ST_RUN);

  // Playlist storage. Writes are accepted in any state; the playing entry is
  // copied into func_q/timer on load, so a rewrite only shows on its next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        func_mem[i]  <= FUNC_ZERO;
        dwell_mem[i] <= '0;
      end
    end else if (sif.cfg_we) begin
      func_mem[sif.cfg_addr]  <= sif.cfg_func;
      dwell_mem[sif.cfg_addr] <= sif.cfg_dwell;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Stop beats both a simultaneous start (in IDLE) and an expiring entry.
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    load_idx   = '0;
    latch_last = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sif.start && !sif.stop) begin
          next_state = ST_RUN;
          load_en    = 1'b1;
          latch_last = 1'b1;
        end
      end
      ST_RUN: begin
        if (sif.stop) begin
          next_state = ST_FINISH;
        end else if (expire) begin
          if (idx_q < last_q) begin
            load_en  = 1'b1;
            load_idx = idx_q + ADDR_W'(1);
          end else if (sif.loop) begin
            load_en  = 1'b1;
          end else begin
            next_state = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      func_q <= FUNC_ZERO;
      idx_q  <= '0;
      last_q <= '0;
    end else begin
      if (latch_last) begin
        last_q <= sif.cfg_last;
      end
      if (load_en) begin
        func_q <= func_mem[load_idx];
        idx_q  <= load_idx;
      end
    end
  end

  waveform_sequencer_dwell_timer #(
    .DWELL_W  (DWELL_W),
    .PRESCALE (PRESCALE)
  ) dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_en),
    .dwell  (dwell_mem[load_idx]),
    .tick   (running),
    .expire (expire)
  );

  // Outputs are gated by state so reset forces them without a clock edge.
  assign sif.func      = running ? func_q : FUNC_ZERO;
  assign sif.entry_idx = running ? idx_q : '0;
  assign sif.busy      = running;
  assign sif.done      = (state == ST_FINISH);

endmodule

// File: tb/tb_waveform_sequencer.sv
// -----------------------------------------------------------------------------
// tb_waveform_sequencer
// Self-checking bench for waveform_sequencer. A behavioural playlist model
// predicts func/entry_idx/busy/done every cycle from the entry hold rule
// (max(dwell,1)*PRESCALE cycles) and the wrap/finish/stop rules.
// -----------------------------------------------------------------------------
module tb_waveform_sequencer;

  import waveform_sequencer_pkg::*;

  localparam int DEPTH    = 8;
  localparam int DWELL_W  = 8;
  localparam int PRESCALE = 4;
  localparam int ADDR_W   = 3;
  localparam int ZERO     = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mdl_func  [DEPTH];
  int   mdl_dwell [DEPTH];

  always #5 clk = ~clk;

  waveform_sequencer_if #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) sif ();

  waveform_sequencer #(
    .DEPTH    (DEPTH),
    .DWELL_W  (DWELL_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  function automatic int hold_cycles(input int d);
    return ((d == 0) ? 1 : d) * PRESCALE;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_func[i]  = ZERO;
      mdl_dwell[i] = 0;
    end
  endtask

  task automatic cfg_write(input int addr, input int f, input int d);
    sif.cfg_we    = 1'b1;
    sif.cfg_addr  = ADDR_W'(addr);
    sif.cfg_func  = 3'(f);
    sif.cfg_dwell = DWELL_W'(d);
    @(posedge clk);
    mdl_func[addr]  = f;
    mdl_dwell[addr] = d;
    #1 sif.cfg_we = 1'b0;
  endtask

  // Starts playback and checks every cycle until the model returns to IDLE.
  // stop_at/start_at/wr_at name the playback cycle (1 = first RUN cycle) on
  // which that input is held high; 0 means never.
  task automatic run_playback(input string tag, input bit lp, input int last,
                              input int stop_at, input int start_at,
                              input int wr_at, input int wr_addr,
                              input int wr_func, input int wr_dwell);
    int phase;
    int cur;
    int rem;
    int cur_func;
    int cyc;
    bit did_stop;
    bit did_wr;
    logic [2:0]        ef;
    logic [ADDR_W-1:0] ei;
    logic              eb;
    logic              ed;
    sif.cfg_last = ADDR_W'(last);
    sif.loop     = lp;
    sif.start    = 1'b1;
    @(posedge clk);
    cur      = 0;
    cur_func = mdl_func[0];
    rem      = hold_cycles(mdl_dwell[0]);
    phase    = 1;
    #1 sif.start = 1'b0;
    cyc = 1;
    while (cyc <= 3000) begin
      ef = (phase == 1) ? 3'(cur_func) : 3'(ZERO);
      ei = (phase == 1) ? ADDR_W'(cur) : '0;
      eb = (phase == 1);
      ed = (phase == 2);
      checks += 4;
      if (sif.func !== ef) begin
        errors++;
        $display("[TB] FAIL %s func cyc=%0d got %0h exp %0h", tag, cyc, sif.func, ef);
      end
      if (sif.entry_idx !== ei) begin
        errors++;
        $display("[TB] FAIL %s entry_idx cyc=%0d got %0d exp %0d", tag, cyc, sif.entry_idx, ei);
      end
      if (sif.busy !== eb) begin
        errors++;
        $display("[TB] FAIL %s busy cyc=%0d got %0b exp %0b", tag, cyc, sif.busy, eb);
      end
      if (sif.done !== ed) begin
        errors++;
        $display("[TB] FAIL %s done cyc=%0d got %0b exp %0b", tag, cyc, sif.done, ed);
      end
      if (phase == 0) break;
      did_stop  = (cyc == stop_at);
      did_wr    = (cyc == wr_at);
      sif.stop  = did_stop;
      sif.start = (cyc == start_at);
      if (did_wr) begin
        sif.cfg_we    = 1'b1;
        sif.cfg_addr  = ADDR_W'(wr_addr);
        sif.cfg_func  = 3'(wr_func);
        sif.cfg_dwell = DWELL_W'(wr_dwell);
      end
      @(posedge clk);
      if (phase == 1) begin
        if (did_stop) begin
          phase = 2;
        end else begin
          rem--;
          if (rem == 0) begin
            if (cur < last) begin
              cur++;
            end else if (lp) begin
              cur = 0;
            end else begin
              phase = 2;
            end
            if (phase == 1) begin
              cur_func = mdl_func[cur];
              rem      = hold_cycles(mdl_dwell[cur]);
            end
          end
        end
      end else begin
        phase = 0;
      end
      if (did_wr) begin
        mdl_func[wr_addr]  = wr_func;
        mdl_dwell[wr_addr] = wr_dwell;
      end
      #1;
      sif.stop   = 1'b0;
      sif.start  = 1'b0;
      sif.cfg_we = 1'b0;
      cyc++;
    end
    if (cyc > 3000) begin
      errors++;
      $display("[TB] FAIL %s timeout got %0d cycles exp idle", tag, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks += 4;
    if (sif.func !== 3'b111) begin
      errors++; $display("[TB] FAIL reset func got %0h exp 7", sif.func);
    end
    if (sif.entry_idx !== '0) begin
      errors++; $display("[TB] FAIL reset entry_idx got %0d exp 0", sif.entry_idx);
    end
    if (sif.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset busy got %0b exp 0", sif.busy);
    end
    if (sif.done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset done got %0b exp 0", sif.done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_edge busy/done got %0b/%0b exp 0/0", sif.busy, sif.done);
    end
    if (sif.func !== 3'b111) begin
      errors++; $display("[TB] FAIL post_reset_edge func got %0h exp 7", sif.func);
    end
  endtask

  task automatic test_single_pass();
    cfg_write(0, 1, 2);
    cfg_write(1, 3, 1);
    run_playback("single_pass", 1'b0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_loop();
    run_playback("loop", 1'b1, 1, 37, 0, 0, 0, 0, 0);
  endtask

  task automatic test_dwell_zero();
    cfg_write(0, 6, 0);
    run_playback("dwell_zero", 1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stop();
    cfg_write(0, 1, 2);
    cfg_write(1, 3, 1);
    run_playback("stop", 1'b0, 1, 5, 0, 0, 0, 0, 0);
  endtask

  task automatic test_start_stop_idle();
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (sif.busy !== 1'b0) begin
        errors++; $display("[TB] FAIL start_stop_idle busy cyc=%0d got %0b exp 0", i, sif.busy);
      end
      if (sif.func !== 3'b111) begin
        errors++; $display("[TB] FAIL start_stop_idle func cyc=%0d got %0h exp 7", i, sif.func);
      end
      @(posedge clk);
      #1;
    end
    run_playback("start_in_run", 1'b0, 1, 0, 6, 0, 0, 0, 0);
  endtask

  task automatic test_rewrite();
    cfg_write(0, 1, 1);
    run_playback("rewrite", 1'b1, 0, 13, 0, 2, 0, 2, 2);
  endtask

  task automatic test_reset_midrun();
    cfg_write(0, 1, 2);
    cfg_write(1, 3, 1);
    sif.cfg_last = ADDR_W'(1);
    sif.loop     = 1'b0;
    sif.start    = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sif.entry_idx !== ADDR_W'(1)) begin
      errors++; $display("[TB] FAIL midrun_pre entry_idx got %0d exp 1", sif.entry_idx);
    end
    #2 rst = 1'b0;
    #1;
    checks += 4;
    if (sif.func !== 3'b111) begin
      errors++; $display("[TB] FAIL midrun_reset func got %0h exp 7", sif.func);
    end
    if (sif.entry_idx !== '0) begin
      errors++; $display("[TB] FAIL midrun_reset entry_idx got %0d exp 0", sif.entry_idx);
    end
    if (sif.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_reset busy got %0b exp 0", sif.busy);
    end
    if (sif.done !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_reset done got %0b exp 0", sif.done);
    end
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_playback("cleared_playlist", 1'b0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      bit lp;
      int last;
      int stop_at;
      for (int a = 0; a < DEPTH; a++) begin
        cfg_write(a, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
      end
      lp      = 1'($urandom_range(1, 0));
      last    = int'($urandom_range(DEPTH - 1, 0));
      stop_at = ($urandom_range(2, 0) == 0 || lp) ? int'($urandom_range(60, 1)) : 0;
      run_playback("random", lp, last, stop_at,
                   int'($urandom_range(40, 1)), int'($urandom_range(30, 1)),
                   int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(7, 0)),
                   int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    sif.cfg_we    = 1'b0;
    sif.cfg_addr  = '0;
    sif.cfg_func  = '0;
    sif.cfg_dwell = '0;
    sif.cfg_last  = '0;
    sif.loop      = 1'b0;
    sif.start     = 1'b0;
    sif.stop      = 1'b0;
    clear_model();
    test_reset();
    test_single_pass();
    test_loop();
    test_dwell_zero();
    test_stop();
    test_start_stop_idle();
    test_rewrite();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_sequencer.md
WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: number of playlist entries (power of two).
REQ-002 Parameter DWELL_W, default 8: width of the per-entry dwell field.
REQ-003 Parameter PRESCALE, default 4: clock cycles per dwell unit, >=1.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  playlist write strobe.
REQ-007 cfg_addr  input  log2(DEPTH)  playlist entry index.
REQ-008 cfg_func  input  3  waveform select written to the entry.
REQ-009 cfg_dwell  input  DWELL_W  dwell count written to the entry.
REQ-010 cfg_last  input  log2(DEPTH)  index of the final entry; sampled on start.
REQ-011 loop  input  1  1 = wrap to entry 0 after the final entry; sampled each wrap decision.
REQ-012 start  input  1  single-cycle request to begin playback.
REQ-013 stop  input  1  single-cycle request to abort playback.
REQ-014 func  output  3  waveform select driven to the waveform generator.
REQ-015 entry_idx  output  log2(DEPTH)  index of the entry currently playing.
REQ-016 busy  output  1  high while in RUN.
REQ-017 done  output  1  one-cycle pulse on completion or abort.

Function
REQ-018 FSM states SHALL be IDLE, RUN, FINISH.
REQ-019 In IDLE, func SHALL be 3'b111 (zero output), busy 0, entry_idx 0.
REQ-020 A cfg_we write SHALL update the addressed entry on the same edge, in any state; a rewrite of the playing entry SHALL take effect only the next time that entry is loaded.
REQ-021 start in IDLE SHALL latch cfg_last, load entry 0, and enter RUN; func SHALL show entry 0 on the next cycle.
REQ-022 start in RUN or FINISH SHALL be ignored.
REQ-023 Each entry SHALL be held for exactly max(dwell,1)*PRESCALE clock cycles; dwell 0 SHALL be treated as 1.
REQ-024 The prescale counter and dwell counter SHALL reload on every entry load.
REQ-025 When an entry expires and entry_idx < latched last, the next entry SHALL load on the following edge with no gap cycle.
REQ-026 When the final entry expires and loop=1, entry 0 SHALL load with no gap cycle and done SHALL NOT pulse.
REQ-027 When the final entry expires and loop=0, the FSM SHALL enter FINISH for one cycle, driving done=1, busy=0, func=3'b111, then return to IDLE.
REQ-028 stop in RUN SHALL enter FINISH on the next edge, with the same outputs as REQ-027.
REQ-029 stop and start asserted together in IDLE: stop SHALL win and no playback SHALL start.
REQ-030 stop in the same cycle that an entry expires SHALL take priority over the advance.
REQ-031 stop in IDLE or FINISH SHALL have no effect.
REQ-032 cfg_last = 0 SHALL play entry 0 alone, honouring loop.

Reset
REQ-033 Asserting rst low SHALL immediately force IDLE, func=3'b111, entry_idx=0, busy=0, done=0, and clear both counters, including mid-playback.
REQ-034 Playlist contents SHALL reset to func=3'b111, dwell=0 for every entry.
REQ-035 No output SHALL change on the first clk edge after rst deasserts unless start is high on that edge.

Structure
REQ-036 The state encoding and the FUNC_ZERO=3'b111 constant SHALL live in a shared package together with the waveform-generator select codes (rhomboid 000, square 001, reciprocal 010, triangle 011, full-wave 100, half-wave 101, sinusoidal 110).
REQ-037 The prescale-plus-dwell counter SHALL be a single sub-module, dwell_timer (load, tick-in, expire-out).
REQ-038 The playlist SHALL be a register array local to this module.

Verification
REQ-039 Write entries {001,2},{011,1}, last=1, loop=0, start -> func=001 for 8 cycles, func=011 for 4 cycles, one-cycle done, then IDLE with func=111.
REQ-040 Same playlist with loop=1 -> pattern 001x8, 011x4 repeats three times with no done pulse and no gap cycles.
REQ-041 Entry {110,0}, last=0, loop=0 -> func=110 for exactly 4 cycles, then done.
REQ-042 stop on cycle 5 of the first entry -> FINISH on the next edge, done=1 for one cycle, then IDLE.
REQ-043 rst low during entry 1 -> all outputs at reset values immediately, without waiting for a clock edge; the playlist is cleared.
REQ-044 start and stop together in IDLE, then start during RUN -> no playback begins, and the later start does not restart or disturb the running sequence.
